// File: rtl/mem_bridge_burst.sv
// Burst copy engine between a DRAM-side and an SD-side memory port.
// Each copied word is also streamed out MSB-first in OUT_W-bit beats.
module mem_bridge_burst #(
  parameter int DATA_W  = 64,
  parameter int OUT_W   = 8,
  parameter int DADDR_W = 13,
  parameter int SADDR_W = 16,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               direction,
  input  logic [DADDR_W-1:0] addr_dram,
  input  logic [SADDR_W-1:0] addr_sd,
  input  logic [LEN_W-1:0]   len,
  output logic               d_req,
  output logic               d_we,
  output logic [DADDR_W-1:0] d_addr,
  output logic [DATA_W-1:0]  d_wdata,
  input  logic               d_ack,
  input  logic [DATA_W-1:0]  d_rdata,
  output logic               s_req,
  output logic               s_we,
  output logic [SADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0]  s_wdata,
  input  logic               s_ack,
  input  logic [DATA_W-1:0]  s_rdata,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_data,
  output logic               done
);
  localparam int BEATS = DATA_W / OUT_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_OUT, S_DONE} state_t;

  state_t             state, state_nx;
  logic               dir_r;
  logic [DADDR_W-1:0] daddr;
  logic [SADDR_W-1:0] saddr;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W:0]     cnt;
  logic [BW-1:0]      beat;
  logic [DATA_W-1:0]  word_buf;

  logic src_ack, dst_ack, last_beat, last_word;

  // Acks are only honoured from the port that is currently requesting.
  assign src_ack   = dir_r ? s_ack : d_ack;
  assign dst_ack   = dir_r ? d_ack : s_ack;
  assign last_beat = (beat == BW'(BEATS - 1));
  assign last_word = (cnt == {1'b0, len_r});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    s_req     = 1'b0;
    s_we      = 1'b0;
    d_wdata   = '0;
    s_wdata   = '0;
    out_valid = 1'b0;
    out_data  = '0;
    done      = 1'b0;
    d_addr    = daddr;
    s_addr    = saddr;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_RD;
      end
      S_RD: begin
        d_req = ~dir_r;
        s_req = dir_r;
        if (src_ack) state_nx = S_WR;
      end
      S_WR: begin
        d_req = dir_r;
        d_we  = dir_r;
        s_req = ~dir_r;
        s_we  = ~dir_r;
        if (dir_r) d_wdata = word_buf;
        else       s_wdata = word_buf;
        if (dst_ack) state_nx = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_data  = word_buf[DATA_W-1 -: OUT_W];
        if (last_beat) state_nx = last_word ? S_DONE : S_RD;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_r    <= 1'b0;
      daddr    <= '0;
      saddr    <= '0;
      len_r    <= '0;
      cnt      <= '0;
      beat     <= '0;
      word_buf <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          dir_r <= direction;
          daddr <= addr_dram;
          saddr <= addr_sd;
          len_r <= len;
          cnt   <= '0;
          beat  <= '0;
        end
        S_RD: if (src_ack) word_buf <= dir_r ? s_rdata : d_rdata;
        S_OUT: begin
          // Shift the next beat up to the MSB slice; the buffer is not needed after the write.
          word_buf <= word_buf << OUT_W;
          if (last_beat) begin
            beat <= '0;
            if (!last_word) begin
              daddr <= daddr + 1'b1;
              saddr <= saddr + 1'b1;
              cnt   <= cnt + 1'b1;
            end
          end else begin
            beat <= beat + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mem_bridge_burst.md
Name: mem_bridge_burst

Overview:
- Parametrised DRAM<->SD transfer engine; successor to the single-word 64-bit bridge.
- Copies a burst of 1..2^LEN_W words between a DRAM-side and an SD-side memory port, in either direction, via req/ack handshakes.
- Streams every transferred word on out_data in OUT_W-bit beats, MSB first. Sits between the command source and the two memory controllers.

Parameters:
- DATA_W, 64, memory word width; must be a multiple of OUT_W.
- OUT_W, 8, output beat width; BEATS = DATA_W/OUT_W.
- DADDR_W, 13, DRAM word-address width.
- SADDR_W, 16, SD word-address width.
- LEN_W, 4, burst-length field width; words per burst = len+1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  command strobe, one cycle; accepted only when in_ready=1.
- in_ready  out  1  high in IDLE only.
- direction  in  1  0: DRAM->SD, 1: SD->DRAM.
- addr_dram  in  DADDR_W  first DRAM word address.
- addr_sd  in  SADDR_W  first SD word address.
- len  in  LEN_W  burst length minus one.
- d_req / d_we  out  1 / 1  DRAM request / write-enable.
- d_addr  out  DADDR_W  DRAM address.
- d_wdata  out  DATA_W  DRAM write data.
- d_ack  in  1  one-cycle DRAM acknowledge.
- d_rdata  in  DATA_W  DRAM read data, valid with d_ack.
- s_req, s_we, s_addr(SADDR_W), s_wdata(DATA_W), s_ack, s_rdata(DATA_W): same contract on the SD side.
- out_valid  out  1  output beat valid.
- out_data  out  OUT_W  output beat.
- done  out  1  one-cycle pulse, burst complete.

Behaviour:
- Reset: all outputs 0, except in_ready=1. FSM to IDLE. Counters and address/data registers cleared. Reset asserted mid-burst aborts immediately; no further req. Partial writes already acked are not undone.
- Command capture: in_valid&&in_ready at edge T latches direction, addresses and len. in_valid while busy is ignored and not queued.
- FSM states: IDLE -> RD -> WR -> OUT -> (RD | DONE) -> IDLE.
- RD: from T+1, the source port (DRAM if direction=0, else SD) drives req=1, we=0, addr=current source address.
  - req and addr are held stable until ack.
  - On the ack edge, rdata is latched into the word buffer; req drops in the next cycle.
- WR: cycle after the read ack, the destination port drives req=1, we=1, current destination address, wdata=word buffer. Held until ack.
- OUT: cycle after the write ack, out_valid=1 for exactly BEATS consecutive cycles.
  - Beat k carries buffer[DATA_W-1-k*OUT_W -: OUT_W].
  - out_data=0 whenever out_valid=0.
- After the last beat: if words remain, both addresses +1 and go to RD. Otherwise go to DONE.
- DONE: done=1 for one cycle, then IDLE with in_ready=1.
- Address wrap: increments are modulo 2^DADDR_W and 2^SADDR_W independently. Example: DRAM 8191 -> 0.
- Ack with no req pending on that port is ignored.
- Ack on the non-active port is ignored.
- Never both ports' req high in the same cycle.
- Word counter width is LEN_W+1. len all-ones gives 2^LEN_W words.
- Minimum per-word latency, acks in the first req cycle: RD 1 + WR 1 + OUT BEATS cycles.
- Data out is ordered by transfer order; no reordering, no buffering beyond one word.

Test Plan:
- Reset: hold rst 2 cycles -> out_valid=0, out_data=0, d_req=s_req=0, done=0, in_ready=1.
- Single word, dir=0, addr_dram=5, addr_sd=100, len=0, DRAM[5]=64'h0123456789ABCDEF, acks in 1 cycle -> s_req/s_we at SD addr 100 with that data; out_data 01,23,45,67,89,AB,CD,EF over 8 consecutive cycles; done one cycle later.
- Burst with wrap, dir=1, addr_sd=65535, addr_dram=8190, len=2 -> SD reads 65535,0,1; DRAM writes 8190,8191,0; three 8-beat output groups in order; single done.
- Ack stalls: d_ack delayed 7 cycles, s_ack delayed 3 -> req/addr/wdata held constant while waiting; output data unchanged; stray s_ack during DRAM read ignored.
- Busy command: in_valid pulse mid-burst with different addresses -> ignored; after done, a new command runs normally.
- Reset mid-burst: rst asserted during WR of word 2 of a 4-word burst -> all outputs 0 in the same cycle (async); no done; next command after release executes correctly.
